// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel fetch handshake between the WS2812 frame sequencer (master) and the
// pixel store / pattern logic (slave).
interface ws2812_frame_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_valid;
    logic [23:0]       pix_data;

    modport master (
        output pix_req,
        output pix_addr,
        input  pix_valid,
        input  pix_data
    );

    modport slave (
        input  pix_req,
        input  pix_addr,
        output pix_valid,
        output pix_data
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// WS2812B frame sequencer: leading RET, NUM_LEDS GRB words fetched with one-deep
// prefetch and serialised MSB-first on dout, trailing RET, then a done pulse.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 8,
    parameter int T0H      = 40,
    parameter int T1H      = 80,
    parameter int TBIT     = 125
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic                ret_en,
    input  logic                ret_done,
    ws2812_frame_ctrl_if.master pix,
    output logic                dout
);
    localparam int TW = $clog2(TBIT);
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TBIT - 1);
    localparam logic [TW-1:0]     T0H_C      = TW'(T0H);
    localparam logic [TW-1:0]     T1H_C      = TW'(T1H);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {IDLE, RET_PRE, FETCH, SEND, RET_POST} state_t;

    state_t            state;
    state_t            state_next;
    logic [TW-1:0]     timer;
    logic [4:0]        bit_idx;
    logic [23:0]       shift_reg;
    logic [23:0]       next_buf;
    logic              next_full;
    logic              last_px;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              dout_q;
    logic              dout_next;
    logic              load_now;
    logic [23:0]       load_data;
    logic              take;
    logic              bit_end;
    logic              px_end;
    logic              buf_avail;

    assign pix.pix_req  = req;
    assign pix.pix_addr = addr;
    assign dout         = dout_q;

    assign take      = req && pix.pix_valid;
    assign bit_end   = (timer == TIMER_LAST);
    assign px_end    = bit_end && (bit_idx == 5'd0);
    // A word arriving exactly on the boundary cycle counts as ready.
    assign buf_avail = next_full || take;

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        ret_en     = (state == RET_PRE) || (state == RET_POST);
        dout_next  = 1'b0;
        load_now   = 1'b0;
        load_data  = next_full ? next_buf : pix.pix_data;
        case (state)
            IDLE:     if (start) state_next = RET_PRE;
            RET_PRE:  if (ret_done) state_next = FETCH;
            FETCH: begin
                if (take) begin
                    state_next = SEND;
                    load_now   = 1'b1;
                    load_data  = pix.pix_data;
                end
            end
            SEND: begin
                dout_next = (timer < (shift_reg[23] ? T1H_C : T0H_C));
                if (px_end) begin
                    if (last_px)        state_next = RET_POST;
                    else if (buf_avail) load_now   = 1'b1;
                    else                state_next = FETCH;
                end
            end
            RET_POST: if (ret_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // dout is registered so the strip pin never sees decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            next_buf  <= '0;
            next_full <= 1'b0;
            last_px   <= 1'b0;
            req       <= 1'b0;
            addr      <= '0;
            dout_q    <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done   <= 1'b0;
            dout_q <= dout_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        underrun  <= 1'b0;
                        addr      <= '0;
                        next_full <= 1'b0;
                    end
                end
                RET_PRE: if (ret_done) req <= 1'b1;
                SEND: begin
                    if (take) begin
                        next_buf  <= pix.pix_data;
                        next_full <= 1'b1;
                        req       <= 1'b0;
                    end
                    if (bit_end) begin
                        timer     <= '0;
                        shift_reg <= shift_reg << 1;
                        bit_idx   <= bit_idx - 5'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    if (px_end && !last_px && !buf_avail) underrun <= 1'b1;
                end
                RET_POST: if (ret_done) done <= 1'b1;
                default: ;
            endcase
            // Loading a word also launches the prefetch of the following pixel.
            if (load_now) begin
                shift_reg <= load_data;
                bit_idx   <= 5'd23;
                timer     <= '0;
                next_full <= 1'b0;
                last_px   <= (addr == LAST_ADDR);
                if (addr != LAST_ADDR) begin
                    addr <= addr + 1'b1;
                    req  <= 1'b1;
                end else begin
                    req <= 1'b0;
                end
            end
        end
    end
endmodule
